// File: rtl/segment_scan_mux.sv
// -----------------------------------------------------------------------------
// segment_scan_mux
//
// Multiplexed seven-segment display driver. DIGITS nibbles are scanned onto a
// shared segment bus, one digit per slot. The inputs are snapshotted once per
// frame so a digit never shows a mix of old and new values. Brightness is a
// PWM window at the start of each slot. The driver also provides optional
// leading-zero blanking, per-digit decimal points and a selectable pin
// polarity.
//
// Parameters
//   DIGITS      number of digits scanned (2..8)
//   CNT_W       width of the slot timing counters
//   ACTIVE_LOW  1 = invert digit_en, segment and dp at the pins
//
// Ports
//   clock         system clock
//   reset         synchronous, active-high reset
//   data          one nibble per digit, digit 0 = data[3:0] = rightmost
//   dp_mask       decimal point request per digit
//   lz_blank      enable leading-zero suppression
//   digit_period  clock cycles per digit slot (0 is treated as 1)
//   on_cycles     lit cycles at the start of each slot
//   digit_en      one-hot digit select (registered)
//   segment       segments, [0]=a .. [6]=g (registered)
//   dp            decimal point (registered)
//   frame_start   one-cycle pulse on the first cycle of every frame
// -----------------------------------------------------------------------------
module segment_scan_mux #(
    parameter int DIGITS     = 4,
    parameter int CNT_W      = 16,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [4*DIGITS-1:0] data,
    input  logic [DIGITS-1:0]   dp_mask,
    input  logic                lz_blank,
    input  logic [CNT_W-1:0]    digit_period,
    input  logic [CNT_W-1:0]    on_cycles,
    output logic [DIGITS-1:0]   digit_en,
    output logic [6:0]          segment,
    output logic                dp,
    output logic                frame_start
);

    localparam int K_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    typedef logic [K_W-1:0] idx_t;

    localparam idx_t              LAST_IDX = idx_t'(DIGITS - 1);
    localparam logic [DIGITS-1:0] ONE_HOT0 = DIGITS'(1);
    localparam logic [DIGITS-1:0] EN_POL   = {DIGITS{ACTIVE_LOW}};
    localparam logic [6:0]        SEG_POL  = {7{ACTIVE_LOW}};

    // Scan state
    logic [CNT_W-1:0]    slot_cnt;
    idx_t                digit_idx;
    // Low while in reset, so the first edge after release enters (k=0, s=0)
    // instead of advancing past it. That edge takes the first snapshot.
    logic                running;

    // Per-frame snapshot of the inputs
    logic [4*DIGITS-1:0] data_sh;
    logic [DIGITS-1:0]   dp_sh;
    logic                lz_sh;

    // Next-state values; the registered outputs are decoded from these
    logic [CNT_W-1:0]    period_m1;
    logic [CNT_W-1:0]    slot_cnt_nxt;
    idx_t                digit_idx_nxt;
    logic                entering;
    logic [4*DIGITS-1:0] data_sh_nxt;
    logic [DIGITS-1:0]   dp_sh_nxt;
    logic                lz_sh_nxt;

    // Output decode
    logic [4*DIGITS-1:0] upper_nibbles;
    logic [DIGITS-1:0]   dp_shifted;
    logic                lit;
    logic                blank;
    logic [DIGITS-1:0]   en_nxt;
    logic [6:0]          seg_nxt;
    logic                dp_nxt;

    // Hex to segments, active-high, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] decode_hex(input logic [3:0] nib);
        case (nib)
            4'h0:    decode_hex = 7'h3F;
            4'h1:    decode_hex = 7'h06;
            4'h2:    decode_hex = 7'h5B;
            4'h3:    decode_hex = 7'h4F;
            4'h4:    decode_hex = 7'h66;
            4'h5:    decode_hex = 7'h6D;
            4'h6:    decode_hex = 7'h7D;
            4'h7:    decode_hex = 7'h07;
            4'h8:    decode_hex = 7'h7F;
            4'h9:    decode_hex = 7'h6F;
            4'hA:    decode_hex = 7'h77;
            4'hB:    decode_hex = 7'h7C;
            4'hC:    decode_hex = 7'h39;
            4'hD:    decode_hex = 7'h5E;
            4'hE:    decode_hex = 7'h79;
            default: decode_hex = 7'h71;
        endcase
    endfunction

    // A period of 0 behaves as 1, so the compare value never underflows.
    assign period_m1 = (digit_period == '0) ? '0 : digit_period - CNT_W'(1);

    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so no
        // path can leave one unassigned and infer a latch.
        slot_cnt_nxt  = slot_cnt + CNT_W'(1);
        digit_idx_nxt = digit_idx;
        entering      = 1'b0;

        if (!running) begin
            slot_cnt_nxt  = '0;
            digit_idx_nxt = '0;
            entering      = 1'b1;
        end else if (slot_cnt >= period_m1) begin
            // The >= compare ends the slot at once if digit_period drops below
            // the current count, rather than wrapping the counter.
            slot_cnt_nxt  = '0;
            digit_idx_nxt = (digit_idx == LAST_IDX) ? '0 : digit_idx + idx_t'(1);
            entering      = (digit_idx == LAST_IDX);
        end

        data_sh_nxt = entering ? data     : data_sh;
        dp_sh_nxt   = entering ? dp_mask  : dp_sh;
        lz_sh_nxt   = entering ? lz_blank : lz_sh;

        // The selected nibble sits in the low bits. The digit is a leading zero
        // when everything from it upward is zero.
        upper_nibbles = data_sh_nxt >> {digit_idx_nxt, 2'b00};
        dp_shifted    = dp_sh_nxt >> digit_idx_nxt;
        blank         = lz_sh_nxt && (digit_idx_nxt != '0) && (upper_nibbles == '0);

        // on_cycles is used live, so a brightness change applies on the next edge.
        lit     = (slot_cnt_nxt < on_cycles);
        en_nxt  = lit ? (ONE_HOT0 << digit_idx_nxt) : '0;
        seg_nxt = (lit && !blank) ? decode_hex(upper_nibbles[3:0]) : 7'h00;
        dp_nxt  = lit && dp_shifted[0];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of its neighbours.
    always_ff @(posedge clock) begin
        if (reset) begin
            slot_cnt    <= '0;
            digit_idx   <= '0;
            running     <= 1'b0;
            data_sh     <= '0;
            dp_sh       <= '0;
            lz_sh       <= 1'b0;
            digit_en    <= EN_POL;
            segment     <= SEG_POL;
            dp          <= ACTIVE_LOW;
            frame_start <= 1'b0;
        end else begin
            slot_cnt    <= slot_cnt_nxt;
            digit_idx   <= digit_idx_nxt;
            running     <= 1'b1;
            data_sh     <= data_sh_nxt;
            dp_sh       <= dp_sh_nxt;
            lz_sh       <= lz_sh_nxt;
            // Polarity is folded in before the register, so the pins come
            // straight from flops.
            digit_en    <= en_nxt ^ EN_POL;
            segment     <= seg_nxt ^ SEG_POL;
            dp          <= dp_nxt ^ ACTIVE_LOW;
            frame_start <= entering;
        end
    end

endmodule

// File: tb/tb_segment_scan_mux.sv
// -----------------------------------------------------------------------------
// tb_segment_scan_mux
//
// Testbench for segment_scan_mux. It runs an active-high and an active-low
// instance side by side on the same stimulus. A behavioural model of the scan
// (slot position, digit number, frame snapshot, decode table) predicts every
// output each cycle. Directed steps cover the documented scenarios, and a
// randomized phase follows them.
// -----------------------------------------------------------------------------
module tb_segment_scan_mux;

    localparam int DIGITS = 4;
    localparam int CNT_W  = 16;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                reset;
    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   dp_mask;
    logic                lz_blank;
    logic [CNT_W-1:0]    digit_period;
    logic [CNT_W-1:0]    on_cycles;

    logic [DIGITS-1:0] en_hi, en_lo;
    logic [6:0]        seg_hi, seg_lo;
    logic              dp_hi, dp_lo, fs_hi, fs_lo;

    int checks = 0;
    int errors = 0;

    segment_scan_mux #(.DIGITS(DIGITS), .CNT_W(CNT_W), .ACTIVE_LOW(1'b0)) dut_hi (
        .clock(clock), .reset(reset), .data(data), .dp_mask(dp_mask),
        .lz_blank(lz_blank), .digit_period(digit_period), .on_cycles(on_cycles),
        .digit_en(en_hi), .segment(seg_hi), .dp(dp_hi), .frame_start(fs_hi)
    );

    segment_scan_mux #(.DIGITS(DIGITS), .CNT_W(CNT_W), .ACTIVE_LOW(1'b1)) dut_lo (
        .clock(clock), .reset(reset), .data(data), .dp_mask(dp_mask),
        .lz_blank(lz_blank), .digit_period(digit_period), .on_cycles(on_cycles),
        .digit_en(en_lo), .segment(seg_lo), .dp(dp_lo), .frame_start(fs_lo)
    );

    // Reference model state
    int   m_pos;              // cycles into the current slot
    int   m_digit;            // digit being scanned
    bit   m_started;
    int   snap_nib [DIGITS];
    bit   snap_dp  [DIGITS];
    bit   snap_lz;
    logic [DIGITS-1:0] x_en;
    logic [6:0]        x_seg;
    logic              x_dp;
    logic              x_fs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Predicts the outputs after the coming clock edge from the inputs as they
    // are now.
    task automatic model_edge();
        int p;
        bit enter;
        bit blank;
        if (reset) begin
            m_pos = 0; m_digit = 0; m_started = 0;
            for (int i = 0; i < DIGITS; i++) begin
                snap_nib[i] = 0;
                snap_dp[i]  = 0;
            end
            snap_lz = 0;
            x_en = '0; x_seg = '0; x_dp = 1'b0; x_fs = 1'b0;
            return;
        end
        p     = (digit_period == 0) ? 1 : int'(digit_period);
        enter = 0;
        if (!m_started) begin
            m_started = 1; m_pos = 0; m_digit = 0; enter = 1;
        end else if (m_pos >= p - 1) begin
            m_pos   = 0;
            m_digit = (m_digit + 1) % DIGITS;
            enter   = (m_digit == 0);
        end else begin
            m_pos++;
        end
        if (enter) begin
            for (int i = 0; i < DIGITS; i++) begin
                snap_nib[i] = int'(data[4*i +: 4]);
                snap_dp[i]  = dp_mask[i];
            end
            snap_lz = lz_blank;
        end
        x_fs = enter;
        if (m_pos < int'(on_cycles)) begin
            blank = snap_lz && (m_digit > 0);
            for (int i = 0; i < DIGITS; i++)
                if (i >= m_digit && snap_nib[i] != 0) blank = 0;
            x_en  = DIGITS'(1 << m_digit);
            x_seg = blank ? 7'h00 : SEG_TABLE[snap_nib[m_digit]];
            x_dp  = snap_dp[m_digit];
        end else begin
            x_en = '0; x_seg = '0; x_dp = 1'b0;
        end
    endtask

    // One clock: predict, take the edge, then compare both instances against
    // the model.
    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
        check("digit_en",      en_hi,  x_en);
        check("segment",       seg_hi, x_seg);
        check("dp",            dp_hi,  x_dp);
        check("frame_start",   fs_hi,  x_fs);
        check("digit_en_al",   en_lo,  DIGITS'(~x_en));
        check("segment_al",    seg_lo, 7'(~x_seg));
        check("dp_al",         dp_lo,  1'(~x_dp));
        check("frame_start_al", fs_lo, x_fs);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Steps until the next frame start, with a bounded wait.
    task automatic sync_frame();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (fs_hi !== 1'b1 && n < 200);
        check("frame_sync", fs_hi, 1'b1);
    endtask

    initial begin
        reset = 1'b1; data = 16'h1234; dp_mask = '0; lz_blank = 1'b0;
        digit_period = 16'd4; on_cycles = 16'd4;

        // Reset state
        run(3);
        check("rst_digit_en",   en_hi,  4'b0000);
        check("rst_segment_al", seg_lo, 7'h7F);
        check("rst_fs",         fs_hi,  1'b0);

        // Basic scan: first edge after release is digit 0 with frame_start
        reset = 1'b0;
        step();
        check("scan0_en",  en_hi,  4'b0001);
        check("scan0_seg", seg_hi, 7'h66);
        check("scan0_fs",  fs_hi,  1'b1);
        run(3);
        step();
        check("scan1_en",  en_hi,  4'b0010);
        check("scan1_seg", seg_hi, 7'h4F);
        run(11);
        step();
        check("frame16_fs", fs_hi, 1'b1);
        check("frame16_en", en_hi, 4'b0001);
        run(15);

        // Reduced duty, then dark
        on_cycles = 16'd1;
        run(32);
        on_cycles = 16'd0;
        run(16);
        sync_frame();
        check("dark_en", en_hi, 4'b0000);
        run(15);

        // Leading-zero blanking with decimal point
        on_cycles = 16'd4; lz_blank = 1'b1; data = 16'h0070; dp_mask = 4'b0100;
        sync_frame();
        check("lz_d0_seg", seg_hi, 7'h3F);
        run(4);
        check("lz_d1_seg", seg_hi, 7'h07);
        run(4);
        check("lz_d2_en",  en_hi,  4'b0100);
        check("lz_d2_seg", seg_hi, 7'h00);
        check("lz_d2_dp",  dp_hi,  1'b1);
        run(4);
        check("lz_d3_seg", seg_hi, 7'h00);
        data = 16'h0000;
        sync_frame();
        check("lz0_d0_seg", seg_hi, 7'h3F);
        run(15);

        // Mid-frame data change stays invisible until the next frame
        lz_blank = 1'b0; dp_mask = '0; data = 16'h1234;
        sync_frame();
        run(4);
        data = 16'h5678;
        run(8);
        check("coherent_d3_seg", seg_hi, 7'h06);
        run(3);
        step();
        check("new_frame_fs",  fs_hi,  1'b1);
        check("new_frame_seg", seg_hi, 7'h7F);
        run(15);

        // Shortening the period mid-slot ends the slot on the next edge
        digit_period = 16'd8; on_cycles = 16'd8;
        sync_frame();
        run(5);
        digit_period = 16'd2;
        step();
        check("short_slot_en", en_hi, 4'b0010);
        run(10);

        // Reset mid-frame aborts it and restarts at digit 0
        digit_period = 16'd8;
        sync_frame();
        run(9);
        reset = 1'b1;
        step();
        check("midrst_en", en_hi, 4'b0000);
        step();
        reset = 1'b0;
        step();
        check("midrst_fs", fs_hi, 1'b1);
        check("midrst_en_after", en_hi, 4'b0001);
        run(20);

        // Active-low pins with an all-segments digit
        digit_period = 16'd4; on_cycles = 16'd4; data = 16'h0008; dp_mask = '0;
        sync_frame();
        check("al_d0_en",  en_lo,  4'b1110);
        check("al_d0_seg", seg_lo, 7'h00);
        check("al_d0_dp",  dp_lo,  1'b1);
        run(15);

        // P = 1: digit_en rotates every cycle
        digit_period = 16'd0; on_cycles = 16'd1;
        run(12);

        // Randomized phase
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                data     = 16'($urandom);
                dp_mask  = 4'($urandom);
                lz_blank = 1'($urandom);
                // Bias toward zero nibbles so blanking gets exercised
                if ($urandom_range(0, 1) == 0) data = data & 16'h00FF;
            end
            if ($urandom_range(0, 39) == 0) digit_period = 16'($urandom_range(0, 6));
            if ($urandom_range(0, 29) == 0) on_cycles    = 16'($urandom_range(0, 7));
            reset = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
